lcd_bus_ctrl: RTL and testbench

Parametrised HD44780-class character-LCD bus controller; successor to the fixed 4-bit nibble writer.
- Accepts one {rs, rw, byte} command per valid/ready handshake.
- Drives the LCD in 4-bit (two nibbles) or 8-bit (one transfer) mode, with all setup, enable, hold, inter-nibble and post-command delays set by parameters.
- Sits between the display-content sequencer and the LCD pins.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_delay_timer.sv | 39 +++
 rtl/lcd_bus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the character-LCD bus controller:
//   - FSM state encoding (state_t and the ST_* constants)
//   - long-wait command decode constants (clear / home)
//   - power-on init nibble constants and the init wait multiplier
//   - helpers: delay_load() turns a cycle count into a down-counter load
//     value, and is_long_cmd() classifies a latched command.
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SETUP     = 3'd1;
  localparam state_t ST_ENABLE    = 3'd2;
  localparam state_t ST_HOLD      = 3'd3;
  localparam state_t ST_GAP       = 3'd4;
  localparam state_t ST_POST_WAIT = 3'd5;

  // Instruction bytes (rs=0) that need the long execution wait.
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Power-on init: 0x3 selects 8-bit interface, 0x2 then drops to 4-bit.
  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  // The first init wait is this many long waits.
  localparam int unsigned INIT_WAIT_MULT = 10;

  // A state lasting N cycles loads N-1 and leaves on zero; N=0 acts as N=1.
  function automatic int unsigned delay_load(input int unsigned cyc);
    return (cyc == 0) ? 0 : cyc - 1;
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// -----------------------------------------------------------------------------
// lcd_delay_timer
// Loadable down-counter shared by every timed state of the LCD controller.
// It loads i_value on i_load, counts down to zero and parks there; it never
// wraps. o_done is high while the count is zero.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears the count)
//   i_load          load i_value this cycle
//   i_value         load value (cycles remaining minus one)
//   o_done          count has reached zero
// -----------------------------------------------------------------------------
module lcd_delay_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_bus_ctrl
// HD44780-class character-LCD bus controller. Accepts one {rs, rw, byte}
// command per valid/ready handshake and drives it onto the LCD pins as two
// nibbles (BUS_WIDTH=4, upper nibble first) or one byte (BUS_WIDTH=8), with
// setup / enable / hold / inter-nibble / post-command delays set by
// parameters. Clear and home instructions get the long post-command wait.
//
// Optional build macro: LCD_INIT_SEQ_EN
//   When defined, the block runs the power-on init sequence by itself after
//   reset release (long wait x10, three 0x3 nibbles, plus 0x2 in 4-bit mode)
//   and only then raises in_ready. When undefined, in_ready rises on the
//   first clock after reset release.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   command handshake (accept on valid & ready)
//   in_rs, in_rw, in_data command fields, latched on accept
//   busy                  transaction (or init) in progress
//   lcd_rs, lcd_rw        LCD RS / RW pins
//   lcd_en                LCD E pin
//   lcd_data              LCD data pins (BUS_WIDTH wide)
// All outputs are flops; no in_* input reaches an output combinationally.
// -----------------------------------------------------------------------------
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = 4,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_CYC        = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned GAP_CYC       = 32,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned LONG_WAIT_CYC = 76000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_rs,
  input  logic                 in_rw,
  input  logic [7:0]           in_data,
  output logic                 busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [BUS_WIDTH-1:0] lcd_data
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(delay_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(delay_load(EN_CYC));
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(delay_load(HOLD_CYC));
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(delay_load(GAP_CYC));
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(delay_load(CMD_WAIT_CYC));
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(delay_load(LONG_WAIT_CYC));

  localparam bit NIBBLE_MODE = (BUS_WIDTH != 8);

`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] LD_INIT    = CNT_W'(delay_load(LONG_WAIT_CYC * INIT_WAIT_MULT));
  // 8-bit mode stops after the three 0x3 writes; 4-bit adds the 0x2 write.
  localparam logic [2:0]       INIT_STEPS = NIBBLE_MODE ? 3'd4 : 3'd3;
`endif

  // Latched transaction context.
  state_t     r_state;
  logic [7:0] r_byte;
  logic       r_lo_phase;   // second (low) nibble of a 4-bit transfer
  logic       r_single;     // init write: one transfer regardless of bus width
  logic       r_long;       // post wait uses LONG_WAIT_CYC

  state_t           w_state_nxt;
  logic [7:0]       w_byte_nxt;
  logic             w_rs_nxt;
  logic             w_rw_nxt;
  logic             w_lo_nxt;
  logic             w_single_nxt;
  logic             w_long_nxt;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_value;
  logic             w_tmr_done;
  logic             w_accept;
  logic             w_ready_nxt;
  logic             w_enter_setup;
  logic [BUS_WIDTH-1:0] w_pin_data;

`ifdef LCD_INIT_SEQ_EN
  logic       r_init_done;
  logic [2:0] r_init_step;
  logic       w_init_done_nxt;
  logic [2:0] w_init_step_nxt;
`endif

  lcd_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  // in_ready is a flop that is high exactly while the FSM sits in IDLE.
  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic. Every timed state was entered with the counter loaded
  // to its length minus one, so w_tmr_done marks its last cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_byte_nxt   = r_byte;
    w_rs_nxt     = lcd_rs;
    w_rw_nxt     = lcd_rw;
    w_lo_nxt     = r_lo_phase;
    w_single_nxt = r_single;
    w_long_nxt   = r_long;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
`ifdef LCD_INIT_SEQ_EN
    w_init_done_nxt = r_init_done;
    w_init_step_nxt = r_init_step;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef LCD_INIT_SEQ_EN
        if (!r_init_done) begin
          // Power-on wait reuses POST_WAIT; it exits into the init writes.
          w_state_nxt = ST_POST_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_INIT;
        end else
`endif
        if (w_accept) begin
          w_state_nxt  = ST_SETUP;
          w_byte_nxt   = in_data;
          w_rs_nxt     = in_rs;
          w_rw_nxt     = in_rw;
          w_lo_nxt     = 1'b0;
          w_single_nxt = 1'b0;
          w_long_nxt   = is_long_cmd(in_rs, in_data);
          w_tmr_load   = 1'b1;
          w_tmr_value  = LD_SETUP;
        end
      end

      ST_SETUP: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_ENABLE;
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_EN;
        end
      end

      ST_ENABLE: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_HOLD;
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_HOLD;
        end
      end

      ST_HOLD: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          if (NIBBLE_MODE && !r_lo_phase && !r_single) begin
            w_state_nxt = ST_GAP;
            w_tmr_value = LD_GAP;
          end else begin
            w_state_nxt = ST_POST_WAIT;
            w_tmr_value = r_long ? LD_LONG : LD_CMD;
          end
        end
      end

      ST_GAP: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_SETUP;
          w_lo_nxt    = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_value = LD_SETUP;
        end
      end

      ST_POST_WAIT: begin
        if (w_tmr_done) begin
`ifdef LCD_INIT_SEQ_EN
          if (!r_init_done) begin
            if (r_init_step == INIT_STEPS) begin
              w_init_done_nxt = 1'b1;
              w_state_nxt     = ST_IDLE;
            end else begin
              // Init nibble sits in the upper half: the 4-bit bus sends only
              // the high nibble, the 8-bit bus sees 0x30 / 0x20.
              w_state_nxt     = ST_SETUP;
              w_byte_nxt      = {(r_init_step == 3'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT, 4'h0};
              w_rs_nxt        = 1'b0;
              w_rw_nxt        = 1'b0;
              w_lo_nxt        = 1'b0;
              w_single_nxt    = 1'b1;
              w_long_nxt      = (r_init_step != 3'd3);
              w_init_step_nxt = r_init_step + 3'd1;
              w_tmr_load      = 1'b1;
              w_tmr_value     = LD_SETUP;
            end
          end else
`endif
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef LCD_INIT_SEQ_EN
  assign w_ready_nxt = (w_state_nxt == ST_IDLE) && w_init_done_nxt;
`else
  assign w_ready_nxt = (w_state_nxt == ST_IDLE);
`endif

  // Pins only change on entry into SETUP (first nibble or second nibble).
  assign w_enter_setup = (w_state_nxt == ST_SETUP) && (r_state != ST_SETUP);

  if (BUS_WIDTH == 8) begin : g_bus8
    assign w_pin_data = w_byte_nxt;
  end else begin : g_bus4
    assign w_pin_data = w_lo_nxt ? w_byte_nxt[3:0] : w_byte_nxt[7:4];
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Outputs are registered from the next-state
  // decode so they line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_lo_phase <= 1'b0;
      r_single   <= 1'b0;
      r_long     <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_lo_phase <= w_lo_nxt;
      r_single   <= w_single_nxt;
      r_long     <= w_long_nxt;
      in_ready   <= w_ready_nxt;
      busy       <= !w_ready_nxt;
      lcd_en     <= (w_state_nxt == ST_ENABLE);
      if (w_enter_setup) begin
        lcd_rs   <= w_rs_nxt;
        lcd_rw   <= w_rw_nxt;
        lcd_data <= w_pin_data;
      end
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
      r_init_step <= 3'd0;
    end else begin
      r_init_done <= w_init_done_nxt;
      r_init_step <= w_init_step_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_ctrl
// Drives a 4-bit and an 8-bit lcd_bus_ctrl instance side by side with small
// delay parameters. Each accepted command pushes its expected LCD transfers
// and busy length onto per-instance queues; a negedge monitor pops and
// compares them as enable pulses and busy windows appear on the pins.
// -----------------------------------------------------------------------------
module tb_lcd_bus_ctrl;

  localparam int unsigned P_SETUP = 1;
  localparam int unsigned P_EN    = 3;
  localparam int unsigned P_HOLD  = 1;
  localparam int unsigned P_GAP   = 4;
  localparam int unsigned P_CMD   = 5;
  localparam int unsigned P_LONG  = 20;
  // Rise-to-rise distance of the two enable pulses in 4-bit mode.
  localparam int EN_SPACING = P_SETUP + P_EN + P_HOLD + P_GAP;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] data;
    bit         second;
  } xfer_t;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] data;
    int         busy4;
    int         busy8;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid4 = 1'b0;
  logic       in_valid8 = 1'b0;
  logic       in_rs = 1'b0;
  logic       in_rw = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready4, busy4, lcd_rs4, lcd_rw4, lcd_en4;
  logic [3:0] lcd_data4;
  logic       in_ready8, busy8, lcd_rs8, lcd_rw8, lcd_en8;
  logic [7:0] lcd_data8;

  always #5 clk = ~clk;

  lcd_bus_ctrl #(
    .BUS_WIDTH(4), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN), .HOLD_CYC(P_HOLD),
    .GAP_CYC(P_GAP), .CMD_WAIT_CYC(P_CMD), .LONG_WAIT_CYC(P_LONG), .CNT_W(20)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_rs(in_rs), .in_rw(in_rw), .in_data(in_data), .busy(busy4),
    .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_en(lcd_en4), .lcd_data(lcd_data4)
  );

  lcd_bus_ctrl #(
    .BUS_WIDTH(8), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN), .HOLD_CYC(P_HOLD),
    .GAP_CYC(P_GAP), .CMD_WAIT_CYC(P_CMD), .LONG_WAIT_CYC(P_LONG), .CNT_W(20)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_rs(in_rs), .in_rw(in_rw), .in_data(in_data), .busy(busy8),
    .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_en(lcd_en8), .lcd_data(lcd_data8)
  );

  int n_vec = 0;
  int n_err = 0;

  xfer_t q_x4[$];
  xfer_t q_x8[$];
  int    q_b4[$];
  int    q_b8[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares pin activity against the scoreboard queues.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  bit prev_en[2];
  bit prev_busy[2];
  int en_len[2];
  int busy_len[2];
  int last_rise[2];

  task automatic mon_step(input int id, input logic en, input logic rs, input logic rw,
                          input logic [7:0] d, input logic bsy, input logic rdy);
    xfer_t x;
    int    eb;
    bit    have;
    string tag;
    tag = (id == 0) ? "dut4" : "dut8";
    if (en) check({"en_only_when_busy_", tag}, bsy, 1'b1);
    if (en && !prev_en[id]) begin
      have = 1'b0;
      if (id == 0 && q_x4.size() > 0) begin x = q_x4.pop_front(); have = 1'b1; end
      if (id == 1 && q_x8.size() > 0) begin x = q_x8.pop_front(); have = 1'b1; end
      check({"en_pulse_expected_", tag}, have, 1'b1);
      if (have) begin
        check({"xfer_rs_", tag}, rs, x.rs);
        check({"xfer_rw_", tag}, rw, x.rw);
        check({"xfer_data_", tag}, d, x.data);
        if (x.second) check({"en_spacing_", tag}, cyc - last_rise[id], EN_SPACING);
      end
      last_rise[id] = cyc;
      en_len[id]    = 1;
    end else if (en) begin
      en_len[id]++;
    end
    if (!en && prev_en[id]) check({"en_width_", tag}, en_len[id], P_EN);

    if (bsy) busy_len[id]++;
    if (!bsy && prev_busy[id]) begin
      eb = -1;
      if (id == 0 && q_b4.size() > 0) eb = q_b4.pop_front();
      if (id == 1 && q_b8.size() > 0) eb = q_b8.pop_front();
      check({"busy_cycles_", tag}, busy_len[id], eb);
      check({"ready_after_busy_", tag}, rdy, 1'b1);
    end
    if (!bsy) busy_len[id] = 0;
    prev_en[id]   = en;
    prev_busy[id] = bsy;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        prev_en[i] = 1'b0; prev_busy[i] = 1'b0; en_len[i] = 0; busy_len[i] = 0;
      end
    end else begin
      mon_step(0, lcd_en4, lcd_rs4, lcd_rw4, {4'h0, lcd_data4}, busy4, in_ready4);
      mon_step(1, lcd_en8, lcd_rs8, lcd_rw8, lcd_data8, busy8, in_ready8);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver. Called at a negedge; presents the command to the selected
  // instances and pushes expectations when each one is seen ready (the
  // accept happens at the following posedge). With keep=1 in_valid stays
  // high after acceptance so the next command can be presented back-to-back.
  // ---------------------------------------------------------------------------
  task automatic send(input logic rs, input logic rw, input logic [7:0] d,
                      input int b4, input int b8, input bit to4, input bit to8, input bit keep);
    bit acc4, acc8, just4, just8;
    int waitc;
    in_rs = rs; in_rw = rw; in_data = d;
    in_valid4 = to4; in_valid8 = to8;
    acc4 = !to4; acc8 = !to8; waitc = 0;
    while (!(acc4 && acc8)) begin
      just4 = 1'b0; just8 = 1'b0;
      if (!acc4 && in_ready4) begin
        q_x4.push_back('{rs, rw, {4'h0, d[7:4]}, 1'b0});
        q_x4.push_back('{rs, rw, {4'h0, d[3:0]}, 1'b1});
        q_b4.push_back(b4);
        acc4 = 1'b1; just4 = 1'b1;
      end
      if (!acc8 && in_ready8) begin
        q_x8.push_back('{rs, rw, d, 1'b1 && 1'b0});
        q_b8.push_back(b8);
        acc8 = 1'b1; just8 = 1'b1;
      end
      @(negedge clk);
      if (just4) check("ready_drop_dut4", in_ready4, 1'b0);
      if (just8) check("ready_drop_dut8", in_ready8, 1'b0);
      if (acc4 && !keep) in_valid4 = 1'b0;
      if (acc8 && !keep) in_valid8 = 1'b0;
      waitc++;
      if (waitc > 200) begin
        check("accept_timeout", {acc4, acc8}, 2'b11);
        in_valid4 = 1'b0; in_valid8 = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (in_ready4 && in_ready8 && q_x4.size() == 0 && q_x8.size() == 0 &&
          q_b4.size() == 0 && q_b8.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_idle_done", done, 1'b1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 19, 10};
    vecs[1] = '{1'b0, 1'b0, 8'h38, 19, 10};
    vecs[2] = '{1'b0, 1'b0, 8'h01, 34, 25};
    vecs[3] = '{1'b1, 1'b0, 8'h01, 19, 10};
    vecs[4] = '{1'b0, 1'b1, 8'h02, 34, 25};
    vecs[5] = '{1'b0, 1'b0, 8'h03, 34, 25};
    vecs[6] = '{1'b0, 1'b0, 8'h04, 19, 10};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 19, 10};
    vecs[8] = '{1'b1, 1'b1, 8'hFF, 19, 10};
    vecs[9] = '{1'b1, 1'b0, 8'hA5, 19, 10};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready4", in_ready4, 1'b0);
    check("rst_busy4",  busy4,     1'b0);
    check("rst_en4",    lcd_en4,   1'b0);
    check("rst_data4",  lcd_data4, 4'h0);
    check("rst_data8",  lcd_data8, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst4", in_ready4, 1'b1);
    check("ready_after_rst8", in_ready8, 1'b1);
    check("busy_after_rst4",  busy4,     1'b0);

    // Table-driven commands on both bus widths.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].rs, vecs[i].rw, vecs[i].data, vecs[i].busy4, vecs[i].busy8, 1'b1, 1'b1, 1'b0);
      wait_idle();
    end

    // Pins keep the last transfer while idle.
    repeat (3) @(negedge clk);
    check("idle_hold_data4", lcd_data4, vecs[9].data[3:0]);
    check("idle_hold_rs4",   lcd_rs4,   vecs[9].rs);
    check("idle_hold_data8", lcd_data8, vecs[9].data);
    check("idle_hold_en4",   lcd_en4,   1'b0);

    // Back-to-back with in_valid held high through busy (4-bit instance).
    send(1'b1, 1'b0, 8'h41, 19, 0, 1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 8'h42, 19, 0, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 8'h01, 34, 0, 1'b1, 1'b0, 1'b1);
    in_valid4 = 1'b0;
    wait_idle();

    // Reset during the first enable pulse aborts the transaction.
    @(negedge clk);
    send(1'b1, 1'b0, 8'h3C, 19, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !lcd_en4; i++) @(negedge clk);
    check("en_seen_before_reset", lcd_en4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_en4",    lcd_en4,   1'b0);
    check("abort_busy4",  busy4,     1'b0);
    check("abort_ready4", in_ready4, 1'b0);
    check("abort_rs4",    lcd_rs4,   1'b0);
    check("abort_data4",  lcd_data4, 4'h0);
    q_x4.delete(); q_b4.delete(); q_x8.delete(); q_b8.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort4", in_ready4, 1'b1);
    check("busy_after_abort4",  busy4,     1'b0);
    send(1'b0, 1'b0, 8'h5A, 19, 10, 1'b1, 1'b1, 1'b0);
    wait_idle();

    check("leftover_xfer4", q_x4.size(), 0);
    check("leftover_xfer8", q_x8.size(), 0);
    check("leftover_busy4", q_b4.size(), 0);
    check("leftover_busy8", q_b8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
